// File: rtl/mod_counter.sv
// mod_counter: programmable-modulus up/down counter with prescaler, load/clear, wrap/saturate and sticky flags
//   clk, rst (async, active-high) | en: count enable | clr, load, load_val: sync clear/load (clr wins)
//   dir: 1 up / 0 down | sat: 1 saturate / 0 wrap | max_val: range 0..max_val | presc: step every presc+1 enabled cycles
//   flag_clr: clears sticky flags | count, at_max, at_zero, wrap pulse, ovf_flag, unf_flag: status
module mod_counter #(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_val,
  input  logic               dir,
  input  logic               sat,
  input  logic [CNT_W-1:0]   max_val,
  input  logic [PRESC_W-1:0] presc,
  input  logic               flag_clr,
  output logic [CNT_W-1:0]   count,
  output logic               at_max,
  output logic               at_zero,
  output logic               wrap,
  output logic               ovf_flag,
  output logic               unf_flag
);
  logic [CNT_W-1:0]   r_count;
  logic [PRESC_W-1:0] r_presc;
  logic               r_wrap, r_ovf, r_unf;
  logic               w_tick, w_step_en, w_up_term, w_dn_term, w_wrap, w_ovf_set, w_unf_set;
  logic [CNT_W-1:0]   w_step, w_load_val;
  // >= rather than == so a prescaler left above a freshly lowered presc ticks at once instead of rolling over
  assign w_tick     = r_presc >= presc;
  assign w_step_en  = en & w_tick & ~clr & ~load;
  assign w_up_term  = r_count >= max_val;
  assign w_dn_term  = r_count == '0;
  assign w_load_val = (load_val > max_val) ? max_val : load_val;
  // down-step above a lowered max_val snaps to max_val so the result stays in range
  assign w_step = dir ? (w_up_term ? (sat ? max_val : '0) : r_count + 1'b1)
                      : (w_dn_term ? (sat ? '0 : max_val)
                                   : ((r_count > max_val) ? max_val : r_count - 1'b1));
  assign w_wrap    = w_step_en & ~sat & (dir ? w_up_term : w_dn_term);
  assign w_ovf_set = w_step_en & dir & w_up_term;
  assign w_unf_set = w_step_en & ~dir & w_dn_term;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (clr || load) begin
        r_count <= clr ? '0 : w_load_val;
        r_presc <= '0;
      end else if (en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_count <= w_step;
      end
      r_wrap <= w_wrap;
      r_ovf  <= w_ovf_set | (r_ovf & ~flag_clr);
      r_unf  <= w_unf_set | (r_unf & ~flag_clr);
    end
  end
  assign count    = r_count;
  assign at_max   = r_count >= max_val;
  assign at_zero  = r_count == '0;
  assign wrap     = r_wrap;
  assign ovf_flag = r_ovf;
  assign unf_flag = r_unf;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: randomized and directed check of mod_counter against a behavioural model
module tb_mod_counter;
  localparam int CW = 16;
  localparam int PW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1, sat = 1'b0, flag_clr = 1'b0;
  logic [CW-1:0] load_val = '0, max_val = 16'd9;
  logic [PW-1:0] presc = '0;
  logic [CW-1:0] count;
  logic          at_max, at_zero, wrap, ovf_flag, unf_flag;
  int            n_chk = 0, n_err = 0;
  int unsigned   m_cnt = 0, m_pc = 0;
  bit            m_wrap = 0, m_ovf = 0, m_unf = 0;
  mod_counter #(.CNT_W(CW), .PRESC_W(PW)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .max_val(max_val), .presc(presc), .flag_clr(flag_clr),
    .count(count), .at_max(at_max), .at_zero(at_zero), .wrap(wrap),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_pc = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
  endtask
  task automatic model_clock();
    int unsigned mx, nxt;
    bit ovf_set, unf_set;
    mx = max_val;
    ovf_set = 0; unf_set = 0; m_wrap = 0;
    if (clr) begin
      m_cnt = 0; m_pc = 0;
    end else if (load) begin
      m_cnt = (load_val < mx) ? load_val : mx; m_pc = 0;
    end else if (en) begin
      if (m_pc >= presc) begin
        m_pc = 0;
        if (dir) begin
          if (m_cnt < mx) nxt = m_cnt + 1;
          else begin
            ovf_set = 1;
            nxt = sat ? mx : 0;
            m_wrap = !sat;
          end
        end else begin
          if (m_cnt == 0) begin
            unf_set = 1;
            nxt = sat ? 0 : mx;
            m_wrap = !sat;
          end else nxt = (m_cnt > mx) ? mx : m_cnt - 1;
        end
        m_cnt = nxt;
      end else m_pc++;
    end
    m_ovf = ovf_set || (m_ovf && !flag_clr);
    m_unf = unf_set || (m_unf && !flag_clr);
  endtask
  task automatic check_all(string tag);
    chk({tag, ".count"}, count, m_cnt);
    chk({tag, ".wrap"}, wrap, m_wrap);
    chk({tag, ".ovf"}, ovf_flag, m_ovf);
    chk({tag, ".unf"}, unf_flag, m_unf);
    chk({tag, ".at_max"}, at_max, m_cnt >= max_val);
    chk({tag, ".at_zero"}, at_zero, m_cnt == 0);
  endtask
  task automatic cyc(int n, string tag);
    repeat (n) begin
      @(posedge clk);
      model_clock();
      #1;
      check_all(tag);
    end
  endtask
  initial begin
    #1;
    check_all("reset");
    chk("reset_at_zero", at_zero, 1);
    #10 rst = 1'b0;
    // up/wrap over 0..9
    dir = 1; sat = 0; en = 1; max_val = 9; presc = 0;
    cyc(12, "up_wrap");
    chk("ovf_after_wrap", ovf_flag, 1);
    // asynchronous reset between edges with count 5 and ovf set
    en = 0; load = 1; load_val = 5;
    cyc(1, "load5");
    load = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_count", count, 0);
    #1 rst = 1'b0;
    en = 1;
    cyc(3, "resume");
    chk("resume_count", count, 3);
    // down/sat from 3
    en = 0; flag_clr = 1; dir = 0; sat = 1; load = 1; load_val = 3;
    cyc(1, "dn_load");
    load = 0; flag_clr = 0; en = 1;
    cyc(5, "dn_sat");
    flag_clr = 1;
    cyc(1, "set_wins");
    chk("unf_set_wins", unf_flag, 1);
    en = 0;
    cyc(1, "flag_clr");
    chk("unf_cleared", unf_flag, 0);
    flag_clr = 0;
    // prescaler with an enable gap
    clr = 1;
    cyc(1, "clr");
    clr = 0; max_val = 255; presc = 2; dir = 1; sat = 0; en = 1;
    cyc(7, "presc");
    en = 0;
    cyc(2, "presc_hold");
    en = 1;
    cyc(6, "presc_resume");
    chk("presc_count", count, 4);
    // priority and clamping
    presc = 0; clr = 1; load = 1; load_val = 7;
    cyc(1, "clr_load");
    chk("clr_over_load", count, 0);
    clr = 0; max_val = 50; load_val = 200;
    cyc(1, "load_clamp");
    chk("load_clamped", count, 50);
    load_val = 40;
    cyc(1, "load40");
    load = 0; max_val = 10; dir = 1;
    cyc(1, "lower_up");
    chk("lower_up_count", count, 0);
    chk("lower_up_ovf", ovf_flag, 1);
    load = 1; max_val = 50;
    cyc(1, "load40b");
    load = 0; max_val = 10; dir = 0;
    cyc(1, "lower_dn");
    chk("lower_dn_count", count, 10);
    // full width free-running
    max_val = 16'hFFFF; load_val = 16'hFFFE; load = 1; dir = 1; sat = 0;
    cyc(1, "w_load");
    load = 0;
    cyc(1, "w_max");
    chk("w_at_max", at_max, 1);
    chk("w_count_max", count, 16'hFFFF);
    cyc(1, "w_wrap");
    chk("w_wrap_pulse", wrap, 1);
    chk("w_count_zero", count, 0);
    cyc(1, "w_after");
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en       = $urandom_range(0, 9) < 8;
      clr      = $urandom_range(0, 49) == 0;
      load     = $urandom_range(0, 29) == 0;
      load_val = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24));
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) sat = ~sat;
      if ($urandom_range(0, 99) == 0)
        max_val = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      if ($urandom_range(0, 79) == 0) presc = 4'($urandom_range(0, 3));
      flag_clr = $urandom_range(0, 19) == 0;
      cyc(1, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
